// File: rtl/booth_seq_mul_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
//   state_e       : FSM states (IDLE, BUSY, DONE)
//   booth_digit_e : recoded Booth digit in {-2,-1,0,+1,+2}
//   iter_count()  : number of radix-4 steps for a given operand width
package booth_seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_e;

    // Operands are extended by 2 bits, so (width+2)/2 digits cover them.
    function automatic int iter_count(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder (combinational).
//   triplet : {y[2i+1], y[2i], y[2i-1]}
//   digit   : recoded digit
module booth_r4_encoder
    import booth_seq_mul_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_e digit
);

    always_comb begin
        digit = ZERO;
        unique case (triplet)
            3'b000, 3'b111: digit = ZERO;
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Radix-4 Booth sequential multiplier, valid/ready on both sides.
// One Booth digit per cycle; K = (WIDTH+2)/2 cycles per product.
// Optional macro BOOTH_SEQ_MUL_EARLY_TERM_EN: finish as soon as the
// unscanned multiplier bits are all equal (remaining digits are zero).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   src_valid/src_ready           : operand handshake
//   multiplicand, multiplier      : WIDTH-bit operands
//   is_signed                     : 1 = two's complement, 0 = unsigned
//   dest_valid/dest_ready/product : 2*WIDTH-bit result handshake
module booth_seq_multiplier
    import booth_seq_mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 is_signed,
    output logic                 dest_valid,
    input  logic                 dest_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int XW = WIDTH + 2;          // extended operand width
    localparam int AW = 2 * XW + 1;         // accumulator width
    localparam int K  = iter_count(WIDTH);
    localparam int CW = $clog2(K + 1);

    state_e               state_q, state_d;
    logic [XW-1:0]        a_q, a_d, y_q, y_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 dest_valid_q, dest_valid_d;

    logic [XW:0]          y_ext;
    logic [2:0]           triplet;
    booth_digit_e         digit;
    logic [XW:0]          a_sx, pp, sum_hi;
    logic [AW-1:0]        acc_step, acc_next;
    logic                 step_done;
    int                   tidx;
`ifdef BOOTH_SEQ_MUL_EARLY_TERM_EN
    logic [XW-1:0]        y_hi;
    int                   y_sh, rem_sh;
`endif

    // Triplet for step i is y[2i+1:2i-1]; y_ext carries the implicit y[-1] = 0.
    always_comb begin
        y_ext   = {y_q, 1'b0};
        tidx    = 2 * int'(cnt_q);
        triplet = y_ext[tidx +: 3];
    end

    booth_r4_encoder u_enc (
        .triplet (triplet),
        .digit   (digit)
    );

    // One Booth step: add digit*A into the upper half, then shift right by 2.
    always_comb begin
        a_sx = {a_q[XW-1], a_q};
        unique case (digit)
            POS1:    pp = a_sx;
            POS2:    pp = a_sx << 1;
            NEG1:    pp = -a_sx;
            NEG2:    pp = -(a_sx << 1);
            default: pp = '0;
        endcase
        sum_hi   = acc_q[AW-1:XW] + pp;
        acc_step = $signed({sum_hi, acc_q[XW-1:0]}) >>> 2;
`ifdef BOOTH_SEQ_MUL_EARLY_TERM_EN
        // y is already sign/zero extended, so an arithmetic shift leaves
        // all-zeros or all-ones exactly when the unscanned bits agree.
        y_sh      = 2 * int'(cnt_q) + 1;
        y_hi      = $signed(y_q) >>> y_sh;
        step_done = (y_hi == '0) || (&y_hi);
        rem_sh    = 2 * (K - 1 - int'(cnt_q));
        acc_next  = $signed(acc_step) >>> rem_sh;
`else
        step_done = (cnt_q == CW'(K - 1));
        acc_next  = acc_step;
`endif
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        y_d          = y_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        product_d    = product_q;
        dest_valid_d = dest_valid_q;
        src_ready    = 1'b0;
        unique case (state_q)
            IDLE: begin
                src_ready = 1'b1;
            end
            BUSY: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (step_done) begin
                    state_d      = DONE;
                    product_d    = acc_next[2*WIDTH-1:0];
                    dest_valid_d = 1'b1;
                end
            end
            DONE: begin
                src_ready = dest_ready;
                if (dest_ready) begin
                    dest_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Capture shared by IDLE and the DONE->BUSY back-to-back path.
        if (src_ready && src_valid) begin
            state_d = BUSY;
            a_d     = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                : {2'b00, multiplicand};
            y_d     = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                : {2'b00, multiplier};
            acc_d   = '0;
            cnt_d   = '0;
        end
        if (rst) src_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            y_q          <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            product_q    <= '0;
            dest_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            y_q          <= y_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            product_q    <= product_d;
            dest_valid_q <= dest_valid_d;
        end
    end

    assign dest_valid = dest_valid_q;
    assign product    = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier (WIDTH = 16).
module tb_booth_seq_multiplier;

    localparam int W  = 16;
    localparam int K  = 9;
    localparam int TO = 60;

    logic           clk = 1'b0;
    logic           rst;
    logic           src_valid;
    logic           src_ready;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           is_signed;
    logic           dest_valid;
    logic           dest_ready;
    logic [2*W-1:0] product;

    int errors = 0;
    int checks = 0;

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .is_signed    (is_signed),
        .dest_valid   (dest_valid),
        .dest_ready   (dest_ready),
        .product      (product)
    );

    always #5 clk = ~clk;

    // Reference: plain integer multiplication, truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        longint pa, pb;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        return (2*W)'(pa * pb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction; returns product, latency (edges from acceptance
    // to dest_valid) and a timeout flag. Consumes after 'hold' stall cycles.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input int hold, output logic [2*W-1:0] p, output int lat,
                           output bit to);
        int n;
        to = 1'b0;
        multiplicand = a; multiplier = b; is_signed = s;
        src_valid = 1'b1; dest_ready = 1'b0;
        n = 0;
        while (!src_ready && n < TO) begin tick(); n++; end
        if (n >= TO) to = 1'b1;
        tick();
        src_valid = 1'b0;
        // Operand changes after acceptance must be ignored.
        multiplicand = W'($urandom); multiplier = W'($urandom); is_signed = 1'($urandom);
        lat = 0;
        while (!dest_valid && lat < TO) begin tick(); lat++; end
        if (lat >= TO) to = 1'b1;
        p = product;
        for (int i = 0; i < hold; i++) tick();
        dest_ready = 1'b1;
        tick();
        dest_ready = 1'b0;
    endtask

    function automatic bit lat_ok(input int lat);
`ifdef BOOTH_SEQ_MUL_EARLY_TERM_EN
        return (lat >= 1) && (lat <= K);
`else
        return lat == K;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; src_valid = 1'b0; dest_ready = 1'b0;
        multiplicand = '0; multiplier = '0; is_signed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dest_valid !== 1'b0 || product !== '0 || src_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: dv=%b prod=%h srdy=%b, want 0/0/0",
                         dest_valid, product, src_ready);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (src_ready !== 1'b1 || dest_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: srdy=%b dv=%b, want 1/0", src_ready, dest_valid);
        end
        tick();
    endtask

    task automatic test_signed_corners();
        logic [W-1:0] ta [3] = '{16'h8000, 16'h7FFF, 16'h8000};
        logic [W-1:0] tb [3] = '{16'h8000, 16'hFFFF, 16'h0000};
        logic [2*W-1:0] want [3] = '{32'h4000_0000, 32'hFFFF_8001, 32'h0};
        logic [2*W-1:0] p; int lat; bit to;
        for (int i = 0; i < 3; i++) begin
            run_txn(ta[i], tb[i], 1'b1, 0, p, lat, to);
            checks++;
            if (to || p !== want[i] || !lat_ok(lat)) begin
                errors++;
                $display("FAIL signed_corner%0d: prod=%h lat=%0d to=%0b, want prod=%h lat=%0d",
                         i, p, lat, to, want[i], K);
            end
        end
    endtask

    task automatic test_unsigned_corners();
        logic [W-1:0] ta [2] = '{16'hFFFF, 16'h8000};
        logic [W-1:0] tb [2] = '{16'hFFFF, 16'h0002};
        logic [2*W-1:0] want [2] = '{32'hFFFE_0001, 32'h0001_0000};
        logic [2*W-1:0] p; int lat; bit to;
        for (int i = 0; i < 2; i++) begin
            run_txn(ta[i], tb[i], 1'b0, 0, p, lat, to);
            checks++;
            if (to || p !== want[i] || !lat_ok(lat)) begin
                errors++;
                $display("FAIL unsigned_corner%0d: prod=%h lat=%0d to=%0b, want prod=%h",
                         i, p, lat, to, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] held;
        int n;
        bit bad;
        multiplicand = 16'd1234; multiplier = 16'hFF00; is_signed = 1'b1;
        src_valid = 1'b1; dest_ready = 1'b0;
        tick();                       // accepted (idle)
        multiplicand = 16'd300; multiplier = 16'd301; is_signed = 1'b0;
        n = 0;
        while (!dest_valid && n < TO) begin tick(); n++; end
        checks++;
        if (n >= TO || product !== ref_mul(16'd1234, 16'hFF00, 1'b1)) begin
            errors++;
            $display("FAIL b2b_first: prod=%h, want %h", product, ref_mul(16'd1234, 16'hFF00, 1'b1));
        end
        held = product;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (product !== held || src_ready !== 1'b0 || dest_valid !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold: prod=%h srdy=%b dv=%b, want %h/0/1",
                     product, src_ready, dest_valid, held);
        end
        dest_ready = 1'b1;
        #1;
        checks++;
        if (src_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: srdy=%b, want 1", src_ready);
        end
        tick();                       // consume + accept on the same edge
        src_valid = 1'b0; dest_ready = 1'b0;
        checks++;
        if (dest_valid !== 1'b0 || src_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: dv=%b srdy=%b, want 0/0", dest_valid, src_ready);
        end
        n = 0;
        while (!dest_valid && n < TO) begin tick(); n++; end
        checks++;
        if (product !== ref_mul(16'd300, 16'd301, 1'b0) || !lat_ok(n)) begin
            errors++;
            $display("FAIL b2b_second: prod=%h lat=%0d, want %h", product, n,
                     ref_mul(16'd300, 16'd301, 1'b0));
        end
        dest_ready = 1'b1;
        tick();
        dest_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] p; int lat; bit to; bit bad;
        multiplicand = 16'd1234; multiplier = 16'd567; is_signed = 1'b0;
        src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();    // three steps done, step 4 in progress
        rst = 1'b1;
        #1;
        checks++;
        if (src_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_srdy: srdy=%b, want 0", src_ready);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (dest_valid !== 1'b0 || product !== '0 || src_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_idle: dv=%b prod=%h srdy=%b, want 0/0/1",
                     dest_valid, product, src_ready);
        end
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dest_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rst_mid_no_output: stray dest_valid, want none");
        end
        run_txn(16'd3, 16'd5, 1'b0, 0, p, lat, to);
        checks++;
        if (to || p !== 32'd15 || !lat_ok(lat)) begin
            errors++;
            $display("FAIL rst_mid_next: prod=%0d lat=%0d, want 15", p, lat);
        end
    endtask

`ifdef BOOTH_SEQ_MUL_EARLY_TERM_EN
    task automatic test_early_term();
        logic [2*W-1:0] p; int lat; bit to;
        run_txn(16'd7, 16'd1, 1'b1, 0, p, lat, to);
        checks++;
        if (to || p !== 32'd7 || lat != 1) begin
            errors++;
            $display("FAIL early_term: prod=%0d lat=%0d, want 7 lat=1", p, lat);
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] a, b; logic s;
        logic [2*W-1:0] p; int lat; bit to;
        int fails = 0;
        for (int t = 0; t < 400; t++) begin
            a = W'($urandom); b = W'($urandom); s = 1'($urandom);
            case ($urandom_range(0, 7))
                0: a = 16'h8000;
                1: b = 16'hFFFF;
                2: b = W'($urandom_range(0, 7));
                default: ;
            endcase
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
            run_txn(a, b, s, int'($urandom_range(0, 3)), p, lat, to);
            checks++;
            if (to || p !== ref_mul(a, b, s) || !lat_ok(lat)) begin
                errors++;
                if (fails < 10)
                    $display("FAIL random%0d: %h*%h s=%b prod=%h lat=%0d, want %h",
                             t, a, b, s, p, lat, ref_mul(a, b, s));
                fails++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_corners();
        test_unsigned_corners();
        test_back_to_back();
        test_reset_mid();
`ifdef BOOTH_SEQ_MUL_EARLY_TERM_EN
        test_early_term();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
